seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a common-anode multi-digit seven-segment display.
- Holds a `DIGITS`-nibble hex value and scans one digit per slot, decoding each nibble to the team's standard 0-F glyph set.
- Adds per-digit decimal points, leading-zero blanking, tear-free frame-synchronous updates and anti-ghost dead time.
- Sits between datapath status registers and the board's segment/anode pins, replacing one combinational decoder per digit.

---
 rtl/seg7_scan_driver_if.sv | 34 +++
 rtl/seg7_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display-side bundle for the seven-segment scan driver.
// master = datapath that loads values and watches status, slave = the driver.
// Optional macro SEG7_BLINK_EN adds the blink enable line.
interface seg7_scan_driver_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_in;
   logic                  blank_lz;
`ifdef SEG7_BLINK_EN
   logic                  blink;
`endif
   logic [7:0]            seg;
   logic [DIGITS-1:0]     an;
   logic                  pending;
   logic                  frame_start;

   modport master (
      output load, value, dp_in, blank_lz,
`ifdef SEG7_BLINK_EN
      output blink,
`endif
      input  seg, an, pending, frame_start
   );

   modport slave (
      input  load, value, dp_in, blank_lz,
`ifdef SEG7_BLINK_EN
      input  blink,
`endif
      output seg, an, pending, frame_start
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode seven-segment driver.
// Scans DIGITS hex nibbles one slot at a time with dp, leading-zero blanking,
// frame-synchronous commit of loaded values and one dead cycle per slot.
// Optional macro SEG7_BLINK_EN adds a frame-counted blink of the anodes.
module seg7_scan_driver #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic              clk,
   input  logic              rst,
   seg7_scan_driver_if.slave bus
);

   localparam int unsigned PC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PC_W-1:0]      pc;
   logic [IDX_W-1:0]     idx;
   logic                 slot_end;
   logic                 wrap;

   logic [4*DIGITS-1:0]  disp_val;
   logic [DIGITS-1:0]    disp_dp;
   logic [4*DIGITS-1:0]  pend_val;
   logic [DIGITS-1:0]    pend_dp;
   logic                 pend_flag;

   logic [DIGITS-1:0]    hi_zero;
   logic [3:0]           cur_nib;
   logic                 cur_dp;
   logic                 cur_hi_zero;
   logic [DIGITS-1:0]    an_sel;
   logic                 blank;
   logic                 dead;
   logic                 hide;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h67;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         4'hF: glyph = 7'h71;
      endcase
   endfunction

   assign slot_end = (pc == PC_W'(REFRESH_DIV - 1));
   assign wrap     = slot_end && (idx == IDX_W'(DIGITS - 1));
   assign dead     = (pc == '0);

   // Slot prescaler and digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc  <= '0;
         idx <= '0;
      end else if (slot_end) begin
         pc  <= '0;
         idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
         pc  <= pc + PC_W'(1);
      end
   end

   // Pending capture and frame-boundary commit into the display register.
   // A load on the wrap cycle commits the old pending value while capturing
   // the new one, so the flag stays set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_val  <= '0;
         disp_dp   <= '0;
         pend_val  <= '0;
         pend_dp   <= '0;
         pend_flag <= 1'b0;
      end else begin
         if (wrap && pend_flag) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
         end
         if (bus.load) begin
            pend_val  <= bus.value;
            pend_dp   <= bus.dp_in;
            pend_flag <= 1'b1;
         end else if (wrap) begin
            pend_flag <= 1'b0;
         end
      end
   end

   // hi_zero[i] is set when nibbles i..DIGITS-1 of the display are all zero.
   always_comb begin
      logic acc;
      hi_zero = '0;
      acc     = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         acc = acc && (disp_val[4*(DIGITS-1-k) +: 4] == 4'h0);
         hi_zero[DIGITS-1-k] = acc;
      end
   end

   // Select the nibble, dp, blanking flag and anode for the current digit.
   always_comb begin
      cur_nib     = '0;
      cur_dp      = 1'b0;
      cur_hi_zero = 1'b0;
      an_sel      = '1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib     = disp_val[4*i +: 4];
            cur_dp      = disp_dp[i];
            cur_hi_zero = hi_zero[i];
            an_sel[i]   = 1'b0;
         end
      end
   end

   assign blank = bus.blank_lz && (idx != '0) && cur_hi_zero;

`ifdef SEG7_BLINK_EN
   localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BF_W-1:0] blink_cnt;
   logic            blink_phase;

   // Frame counter: phase toggles every BLINK_FRAMES frames.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (wrap) begin
         if (blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt   <= blink_cnt + BF_W'(1);
         end
      end
   end

   assign hide = bus.blink && blink_phase;
`else
   assign hide = 1'b0;
`endif

   // Registered pin drivers; outputs lag the pc/idx state by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.seg         <= 8'hFF;
         bus.an          <= '1;
         bus.frame_start <= 1'b0;
      end else begin
         bus.seg         <= {~cur_dp, blank ? 7'h7F : ~glyph(cur_nib)};
         bus.an          <= (dead || hide) ? '1 : an_sel;
         bus.frame_start <= wrap;
      end
   end

   assign bus.pending = pend_flag;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver, DIGITS=4, REFRESH_DIV=4.
// Expected per-cycle anode/segment/frame_start values are queued per frame
// and popped as the display scans.
module tb_seg7_scan_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   typedef struct {
      logic [3:0] an;
      logic [7:0] seg;
      logic       fs;
      logic       lit;
   } exp_t;

   exp_t q[$];

   logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg7_scan_driver_if #(.DIGITS(4)) bus ();

   seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Advance to the next frame_start pulse, bounded.
   task automatic wait_frame(input string tag);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.frame_start === 1'b1) break;
      end
      chk({tag, "_frame_start"}, {15'd0, bus.frame_start}, 16'd1);
   endtask

   // Called at the negedge where frame_start is high; checks the whole next frame.
   task automatic check_frame(input logic [15:0] v, input logic [3:0] dp,
                              input logic blz, input string tag);
      exp_t e;
      for (int d = 0; d < 4; d++) begin
         logic [3:0]  nib;
         logic [15:0] hi;
         logic        blank;
         logic [7:0]  s;
         nib   = v[4*d +: 4];
         hi    = v >> (4*d);
         blank = blz && (d > 0) && (hi == 16'd0);
         s     = {~dp[d], blank ? 7'h7F : ~glyph_tab[nib]};
         e = '{an: 4'hF, seg: 8'h00, fs: 1'b0, lit: 1'b0};
         q.push_back(e);
         for (int k = 0; k < 3; k++) begin
            e = '{an: ~(4'b0001 << d), seg: s, fs: (d == 3 && k == 2), lit: 1'b1};
            q.push_back(e);
         end
      end
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         e = q.pop_front();
         chk({tag, "_an"}, {12'd0, bus.an}, {12'd0, e.an});
         chk({tag, "_fs"}, {15'd0, bus.frame_start}, {15'd0, e.fs});
         if (e.lit) chk({tag, "_seg"}, {8'd0, bus.seg}, {8'd0, e.seg});
      end
   endtask

   initial begin
      bus.load     = 1'b0;
      bus.value    = '0;
      bus.dp_in    = '0;
      bus.blank_lz = 1'b0;
`ifdef SEG7_BLINK_EN
      bus.blink    = 1'b0;
`endif

      // Reset values and first cycles after release.
      repeat (2) @(negedge clk);
      chk("rst_seg", {8'd0, bus.seg}, 16'h00FF);
      chk("rst_an", {12'd0, bus.an}, 16'h000F);
      chk("rst_pending", {15'd0, bus.pending}, 16'd0);
      chk("rst_fs", {15'd0, bus.frame_start}, 16'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("first_an_dead", {12'd0, bus.an}, 16'h000F);
      @(negedge clk);
      chk("second_an", {12'd0, bus.an}, 16'h000E);
      chk("second_seg", {8'd0, bus.seg}, 16'h00C0);
      wait_frame("boot");
      check_frame(16'h0000, 4'b0000, 1'b0, "idle");

      // Load mid-frame at pc=1 of digit 1.
      repeat (5) @(negedge clk);
      bus.load  = 1'b1;
      bus.value = 16'h1A3F;
      bus.dp_in = 4'b0100;
      @(negedge clk);
      bus.load  = 1'b0;
      chk("load_pending", {15'd0, bus.pending}, 16'd1);
      wait_frame("load1");
      chk("commit_pending_clr", {15'd0, bus.pending}, 16'd0);
      check_frame(16'h1A3F, 4'b0100, 1'b0, "v1A3F");

      // Leading-zero blanking.
      bus.blank_lz = 1'b1;
      bus.load     = 1'b1;
      bus.value    = 16'h0050;
      bus.dp_in    = 4'b0000;
      @(negedge clk);
      bus.load     = 1'b0;
      wait_frame("load2");
      check_frame(16'h0050, 4'b0000, 1'b1, "blank");
      bus.blank_lz = 1'b0;

      // Two loads within one frame: last wins.
      bus.load  = 1'b1;
      bus.value = 16'h1111;
      @(negedge clk);
      bus.value = 16'h2222;
      @(negedge clk);
      bus.load  = 1'b0;
      chk("dbl_pending", {15'd0, bus.pending}, 16'd1);
      wait_frame("load3");
      check_frame(16'h2222, 4'b0000, 1'b0, "last_wins");

      // Load on the wrap cycle while 4444 is pending.
      bus.load  = 1'b1;
      bus.value = 16'h4444;
      @(negedge clk);
      bus.load  = 1'b0;
      repeat (14) @(negedge clk);
      bus.load  = 1'b1;
      bus.value = 16'h3333;
      @(negedge clk);
      bus.load  = 1'b0;
      chk("wrapload_fs", {15'd0, bus.frame_start}, 16'd1);
      chk("wrapload_pending", {15'd0, bus.pending}, 16'd1);
      check_frame(16'h4444, 4'b0000, 1'b0, "wrap_old");
      chk("wrapload_pending_clr", {15'd0, bus.pending}, 16'd0);
      check_frame(16'h3333, 4'b0000, 1'b0, "wrap_new");

      // Asynchronous reset mid-frame discards a pending value.
      bus.load  = 1'b1;
      bus.value = 16'h5555;
      bus.dp_in = 4'b1111;
      @(negedge clk);
      bus.load  = 1'b0;
      chk("pre_rst_pending", {15'd0, bus.pending}, 16'd1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_seg", {8'd0, bus.seg}, 16'h00FF);
      chk("arst_an", {12'd0, bus.an}, 16'h000F);
      chk("arst_pending", {15'd0, bus.pending}, 16'd0);
      chk("arst_fs", {15'd0, bus.frame_start}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rerst_an_dead", {12'd0, bus.an}, 16'h000F);
      @(negedge clk);
      chk("rerst_an", {12'd0, bus.an}, 16'h000E);
      chk("rerst_seg", {8'd0, bus.seg}, 16'h00C0);
      wait_frame("rerst");
      check_frame(16'h0000, 4'b0000, 1'b0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
